picosoc_mem_arbiter: RTL and testbench
======================================

// Module: picosoc_mem_arbiter
// PURPOSE
//  Two-master arbiter sharing the PicoSoC native memory bus (valid/ready/addr/wdata/wstrb/rdata).
//  M0 is the picorv32 core; M1 is a DMA/debug master. The single slave side drives the existing
//  decode (RAM, spimemio, UART, iomem). A bus watchdog ends hung transactions (unmapped iomem) with
//  a fixed read value and a sticky error flag.
// PARAMETERS
//  TIMEOUT_CYCLES  1024          cycles in BUSY without s_ready before forced completion; 0 = disabled
//  TIMEOUT_RDATA   32'hDEAD_BEEF rdata returned to the master on timeout
//  PRIO_M0         0             1 = M0 fixed priority; 0 = round-robin
// PORTS
//  clk             in   1   system clock
//  reset           in   1   synchronous, active-high reset
//  m0_valid        in   1   M0 request; held stable until m0_ready
//  m0_instr        in   1   M0 instruction fetch
//  m0_addr         in   32  M0 address
//  m0_wdata        in   32  M0 write data
//  m0_wstrb        in   4   M0 byte strobes; 0 = read
//  m0_ready        out  1   one-cycle completion pulse to M0
//  m0_rdata        out  32  read data to M0, valid while m0_ready
//  m1_*            (same set as m0_*, for M1)
//  s_valid         out  1   request to slave decode
//  s_instr         out  1   granted master's instr
//  s_addr          out  32  granted master's addr
//  s_wdata         out  32  granted master's wdata
//  s_wstrb         out  4   granted master's wstrb
//  s_ready         in   1   slave completion
//  s_rdata         in   32  slave read data
//  s_owner         out  1   index of granted master (valid while s_valid)
//  err_timeout     out  1   sticky: a timeout occurred
//  err_addr        out  32  address of the most recent timed-out transfer
//  err_clear       in   1   clears err_timeout
// BEHAVIOUR
//  - Reset: state=IDLE, s_valid=0, m0/m1_ready=0, s_owner=0, last_grant=1, err_timeout=0,
//    err_addr=0, timeout counter=0. Reset mid-transfer drops s_valid the next cycle; no ready is issued.
//  - FSM IDLE: if any mX_valid, pick a winner, register grant, go BUSY. Arbitration latency = 1 cycle.
//    Choice: PRIO_M0=1 -> M0 whenever m0_valid. Else round-robin: if both are valid, the master
//    != last_grant wins; if only one is valid, it wins.
//  - FSM BUSY: s_valid=1; s_* are muxed combinationally from the granted master's stable inputs.
//    On s_ready: mG_ready=1 and mG_rdata=s_rdata in the same cycle; last_grant<=G; go IDLE.
//    Minimum transfer cycle is 2 (arbitrate + complete); back-to-back grants have 1 idle cycle between.
//  - Non-granted mX_ready is always 0. mX_rdata is 0 when mX_ready=0.
//  - Timeout: the counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
//    When count==TIMEOUT_CYCLES-1 and s_ready=0: mG_ready=1, mG_rdata=TIMEOUT_RDATA,
//    err_timeout<=1, err_addr<=s_addr, go IDLE. s_ready in that same cycle takes precedence (normal end).
//  - err_clear and a new timeout in the same cycle: set wins. Write timeouts also complete silently.
//  - Granted master drops valid while BUSY (protocol violation or master reset): abort to IDLE,
//    no ready pulse, last_grant is not updated.
//  - Counter width = $clog2(TIMEOUT_CYCLES+1). TIMEOUT_CYCLES=0 never fires.
// STRUCTURE
//  - Shared package picosoc_bus_pkg: FSM state encoding (ST_IDLE, ST_BUSY), master IDs
//    (MST_CPU=0, MST_DMA=1), default TIMEOUT_RDATA constant.
//  - Sub-module picosoc_bus_timeout: clear/enable counter with an expired pulse output,
//    parameterised by TIMEOUT_CYCLES. All other logic is inline.
// TESTING
//  - Reset: assert reset with m0_valid=1 -> s_valid=0 and m0_ready=0 during reset; first grant is
//    M0 (s_owner=0) 1 cycle after release.
//  - Contention RR: M0 and M1 issue continuous reads to 0x0000_0010/0x0000_0020 -> grants alternate
//    0,1,0,1; each master receives its own s_rdata; no master is starved over 100 transfers.
//  - PRIO_M0=1: both valid continuously -> M1 is never granted while m0_valid stays high.
//  - Timeout: TIMEOUT_CYCLES=16; M1 reads 0x0300_0000 and the slave never readies -> m1_ready on
//    BUSY cycle 16 with rdata 0xDEADBEEF; err_timeout=1; err_addr=0x0300_0000; err_clear -> 0.
//  - Boundary: s_ready arrives on the expiry cycle -> normal completion, err_timeout stays 0; both
//    err_clear and a new timeout in the same cycle -> err_timeout=1.
//  - Abort: reset asserted, or granted m0_valid dropped, mid-BUSY -> s_valid=0 next cycle, no
//    m0_ready, and M1 is granted as the next master.

Source files
------------

// File: rtl/picosoc_bus_pkg.sv
// ============================================================================
//  Module   : picosoc_bus_pkg
//  Purpose  : Shared constants for the PicoSoC native-bus arbiter slice:
//             FSM state encoding, master IDs and the default timeout rdata.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package picosoc_bus_pkg;

  // Arbiter FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Master IDs, also the value presented on s_owner
  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DMA = 1'b1;

  // Read value handed back when the watchdog forces completion
  localparam logic [31:0] c_DEFAULT_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

`default_nettype wire

// File: rtl/picosoc_bus_timeout.sv
// ============================================================================
//  Module   : picosoc_bus_timeout
//  Purpose  : Bus watchdog counter. Held at zero by clear, counts cycles in
//             which enable is high, and flags expiry combinationally on the
//             enabled cycle where the count reaches TIMEOUT_CYCLES-1.
//             TIMEOUT_CYCLES = 0 removes the counter and never expires.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module picosoc_bus_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      // Watchdog disabled: inputs are intentionally left unused
      logic w_unused;
      assign w_unused = &{1'b0, clk, reset, clear, enable};
      assign expired  = 1'b0;
    end else begin : g_counter
      localparam int unsigned   c_W    = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [c_W-1:0] c_LAST = c_W'(TIMEOUT_CYCLES - 1);

      logic [c_W-1:0] r_count;

      // Count enabled cycles; clear has priority so every transfer starts at zero
      always_ff @(posedge clk) begin
        if (reset || clear) begin
          r_count <= '0;
        end else if (enable) begin
          r_count <= r_count + 1'b1;
        end
      end

      assign expired = enable && (r_count == c_LAST);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/picosoc_mem_arbiter.sv
// ============================================================================
//  Module   : picosoc_mem_arbiter
//  Purpose  : Two-master arbiter for the PicoSoC native memory bus. M0 is the
//             core, M1 a DMA/debug master. One cycle of arbitration in IDLE,
//             then the granted master's request is muxed onto the slave side
//             until s_ready, a watchdog expiry, or the master withdrawing.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module picosoc_mem_arbiter
  import picosoc_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = c_DEFAULT_TIMEOUT_RDATA,
  parameter bit          PRIO_M0        = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        s_owner,
  output logic        err_timeout,
  output logic [31:0] err_addr,
  input  logic        err_clear
);

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic        r_grant;
  logic        r_last_grant;
  logic        w_winner;
  logic        r_err_timeout;
  logic [31:0] r_err_addr;
  logic        w_expired;

  // Transfer-ending conditions while BUSY. A withdrawn request aborts and
  // overrides everything; s_ready beats the watchdog in the same cycle.
  logic w_busy, w_g_valid, w_abort, w_done_ok, w_done_to, w_done;
  assign w_busy    = (r_state == ST_BUSY);
  assign w_g_valid = (r_grant == MST_DMA) ? m1_valid : m0_valid;
  assign w_abort   = w_busy && !w_g_valid;
  assign w_done_ok = w_busy && w_g_valid && s_ready;
  assign w_done_to = w_busy && w_g_valid && !s_ready && w_expired;
  assign w_done    = w_done_ok || w_done_to;

  // Watchdog: held clear in IDLE, counts BUSY cycles the slave leaves unanswered
  picosoc_bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (!w_busy),
    .enable  (w_busy && w_g_valid && !s_ready),
    .expired (w_expired)
  );

  // Arbitration choice: fixed M0 priority, or alternate away from the last completed grant
  always_comb begin
    if (m0_valid && m1_valid) begin
      w_winner = PRIO_M0 ? MST_CPU : ~r_last_grant;
    end else begin
      w_winner = m1_valid ? MST_DMA : MST_CPU;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (m0_valid || m1_valid) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_abort || w_done)    w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: slave-side mux and per-master completion pulses
  always_comb begin
    s_valid  = w_busy;
    s_owner  = r_grant;
    s_instr  = (r_grant == MST_DMA) ? m1_instr : m0_instr;
    s_addr   = (r_grant == MST_DMA) ? m1_addr  : m0_addr;
    s_wdata  = (r_grant == MST_DMA) ? m1_wdata : m0_wdata;
    s_wstrb  = (r_grant == MST_DMA) ? m1_wstrb : m0_wstrb;
    m0_ready = w_done && (r_grant == MST_CPU);
    m1_ready = w_done && (r_grant == MST_DMA);
    m0_rdata = '0;
    m1_rdata = '0;
    if (m0_ready) m0_rdata = w_done_ok ? s_rdata : TIMEOUT_RDATA;
    if (m1_ready) m1_rdata = w_done_ok ? s_rdata : TIMEOUT_RDATA;
  end

  // Register the winner on grant; last_grant moves only on a completed transfer (not on abort)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant      <= MST_CPU;
      r_last_grant <= MST_DMA;
    end else begin
      if ((r_state == ST_IDLE) && (m0_valid || m1_valid)) r_grant <= w_winner;
      if (w_done) r_last_grant <= r_grant;
    end
  end

  // Sticky timeout flag and address capture; a new timeout outranks err_clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_timeout <= 1'b0;
      r_err_addr    <= '0;
    end else if (w_done_to) begin
      r_err_timeout <= 1'b1;
      r_err_addr    <= s_addr;
    end else if (err_clear) begin
      r_err_timeout <= 1'b0;
    end
  end

  assign err_timeout = r_err_timeout;
  assign err_addr    = r_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_picosoc_mem_arbiter.sv
// ============================================================================
//  Module   : tb_picosoc_mem_arbiter
//  Purpose  : Self-checking bench for picosoc_mem_arbiter. Main instance runs
//             round-robin with a 16-cycle watchdog; a second instance runs
//             with fixed M0 priority. Expected completions are queued when a
//             request is issued and popped on each ready pulse.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_picosoc_mem_arbiter;

  localparam logic [31:0] c_SLV_XOR = 32'hA5A5_0000;
  localparam logic [31:0] c_FIXED   = 32'h1234_5678;
  localparam logic [31:0] c_TO_DATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr, s_ready, s_owner;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        err_timeout, err_clear;
  logic [31:0] err_addr;

  // Priority instance signals
  logic        b_m0_valid, b_m1_valid;
  logic        b_m0_ready, b_m1_ready;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_s_valid, b_s_instr, b_s_ready, b_s_owner;
  logic [31:0] b_s_addr, b_s_wdata, b_s_rdata;
  logic [3:0]  b_s_wstrb;
  logic        b_err_timeout;
  logic [31:0] b_err_addr;

  always #5 clk = ~clk;

  picosoc_mem_arbiter #(
    .TIMEOUT_CYCLES (16),
    .TIMEOUT_RDATA  (c_TO_DATA),
    .PRIO_M0        (1'b0)
  ) dut (
    .clk (clk), .reset (reset),
    .m0_valid (m0_valid), .m0_instr (m0_instr), .m0_addr (m0_addr),
    .m0_wdata (m0_wdata), .m0_wstrb (m0_wstrb), .m0_ready (m0_ready), .m0_rdata (m0_rdata),
    .m1_valid (m1_valid), .m1_instr (m1_instr), .m1_addr (m1_addr),
    .m1_wdata (m1_wdata), .m1_wstrb (m1_wstrb), .m1_ready (m1_ready), .m1_rdata (m1_rdata),
    .s_valid (s_valid), .s_instr (s_instr), .s_addr (s_addr), .s_wdata (s_wdata),
    .s_wstrb (s_wstrb), .s_ready (s_ready), .s_rdata (s_rdata), .s_owner (s_owner),
    .err_timeout (err_timeout), .err_addr (err_addr), .err_clear (err_clear)
  );

  picosoc_mem_arbiter #(
    .TIMEOUT_CYCLES (16),
    .TIMEOUT_RDATA  (c_TO_DATA),
    .PRIO_M0        (1'b1)
  ) dut_prio (
    .clk (clk), .reset (reset),
    .m0_valid (b_m0_valid), .m0_instr (1'b0), .m0_addr (32'h0000_0010),
    .m0_wdata (32'h0), .m0_wstrb (4'h0), .m0_ready (b_m0_ready), .m0_rdata (b_m0_rdata),
    .m1_valid (b_m1_valid), .m1_instr (1'b0), .m1_addr (32'h0000_0020),
    .m1_wdata (32'h0), .m1_wstrb (4'h0), .m1_ready (b_m1_ready), .m1_rdata (b_m1_rdata),
    .s_valid (b_s_valid), .s_instr (b_s_instr), .s_addr (b_s_addr), .s_wdata (b_s_wdata),
    .s_wstrb (b_s_wstrb), .s_ready (b_s_ready), .s_rdata (b_s_rdata), .s_owner (b_s_owner),
    .err_timeout (b_err_timeout), .err_addr (b_err_addr), .err_clear (1'b0)
  );

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
    int          busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   slave_mode;   // 0: never ready, 1: ready on first BUSY cycle, 2: ready on BUSY cycle ready_at
  int   ready_at;
  int   busy_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Compare every ready pulse against the oldest queued expectation
  task automatic monitor();
    exp_t e;
    if (!m0_ready) check("m0_rdata_zero", m0_rdata, 32'd0);
    if (!m1_ready) check("m1_rdata_zero", m1_rdata, 32'd0);
    if (m0_ready || m1_ready) begin
      check("dual_ready", 32'(m0_ready & m1_ready), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("owner", 32'(m1_ready), 32'(e.owner));
        check("rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
        check("busy_cycles", 32'(busy_n), 32'(e.busy));
      end
    end
  endtask

  // One clock: slave models respond 1 time unit after the edge, checks 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
    if (s_valid) busy_n++;
    else busy_n = 0;
    case (slave_mode)
      1:       s_ready = s_valid;
      2:       s_ready = s_valid && (busy_n == ready_at);
      default: s_ready = 1'b0;
    endcase
    s_rdata   = !s_ready ? 32'd0 : (slave_mode == 2) ? c_FIXED : (s_addr ^ c_SLV_XOR);
    b_s_ready = b_s_valid;
    b_s_rdata = b_s_addr;
    #1;
    monitor();
  endtask

  // Run until all queued completions are seen (bounded), then one idle cycle
  task automatic wait_done(input int bound);
    int n = 0;
    while (sb.size() > 0 && n < bound) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check("wait_bound", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    tick();
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int n_b;
    reset = 1'b1; err_clear = 1'b0;
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready = 1'b0; s_rdata = '0; b_s_ready = 1'b0; b_s_rdata = '0;
    b_m0_valid = 1'b0; b_m1_valid = 1'b0;
    slave_mode = 1; ready_at = 0; busy_n = 0;

    // Reset held with a pending M0 request
    m0_valid = 1'b1; m0_addr = 32'h0000_0010;
    repeat (3) begin
      tick();
      check("rst_s_valid", 32'(s_valid), 32'd0);
      check("rst_m0_ready", 32'(m0_ready), 32'd0);
      check("rst_err", 32'(err_timeout), 32'd0);
      check("rst_err_addr", err_addr, 32'd0);
    end
    sb.push_back('{1'b0, 32'h0000_0010 ^ c_SLV_XOR, 1});
    reset = 1'b0;
    tick();
    check("rel_s_valid", 32'(s_valid), 32'd1);
    check("rel_owner", 32'(s_owner), 32'd0);
    wait_done(4);
    m0_valid = 1'b0;

    // Round-robin contention over 100 transfers
    reset_pulse();
    m0_addr = 32'h0000_0010; m1_addr = 32'h0000_0020;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) sb.push_back('{1'b0, 32'h0000_0010 ^ c_SLV_XOR, 1});
      else            sb.push_back('{1'b1, 32'h0000_0020 ^ c_SLV_XOR, 1});
    end
    m0_valid = 1'b1; m1_valid = 1'b1;
    wait_done(300);
    m0_valid = 1'b0; m1_valid = 1'b0;

    // Watchdog on an unmapped M1 read
    slave_mode = 0;
    m1_addr = 32'h0300_0000;
    sb.push_back('{1'b1, c_TO_DATA, 16});
    m1_valid = 1'b1;
    wait_done(40);
    m1_valid = 1'b0;
    check("to_err", 32'(err_timeout), 32'd1);
    check("to_err_addr", err_addr, 32'h0300_0000);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("to_err_cleared", 32'(err_timeout), 32'd0);

    // s_ready on the expiry cycle completes normally
    slave_mode = 2; ready_at = 16;
    m0_addr = 32'h0300_0004;
    sb.push_back('{1'b0, c_FIXED, 16});
    m0_valid = 1'b1;
    wait_done(40);
    m0_valid = 1'b0;
    check("bnd_err_stays", 32'(err_timeout), 32'd0);

    // err_clear held through a new timeout: set wins
    slave_mode = 0;
    m1_addr = 32'h0300_0008;
    err_clear = 1'b1;
    sb.push_back('{1'b1, c_TO_DATA, 16});
    m1_valid = 1'b1;
    wait_done(40);
    m1_valid = 1'b0;
    err_clear = 1'b0;
    check("set_wins_err", 32'(err_timeout), 32'd1);
    check("set_wins_addr", err_addr, 32'h0300_0008);

    // Abort: granted M0 withdraws mid-BUSY, M1 goes next
    reset_pulse();
    slave_mode = 2; ready_at = 2;
    m0_addr = 32'h0000_0010; m1_addr = 32'h0000_0020;
    m0_valid = 1'b1; m1_valid = 1'b1;
    tick();
    check("ab_busy", 32'(s_valid), 32'd1);
    check("ab_owner", 32'(s_owner), 32'd0);
    m0_valid = 1'b0;
    #1;
    check("ab_no_ready", 32'(m0_ready), 32'd0);
    sb.push_back('{1'b1, c_FIXED, 2});
    tick();
    check("ab_drop", 32'(s_valid), 32'd0);
    wait_done(10);
    m1_valid = 1'b0;

    // Abort: reset mid-BUSY (master reset drops M0 too), M1 goes next
    slave_mode = 0;
    m0_valid = 1'b1; m1_valid = 1'b1;
    tick();
    check("rb_owner", 32'(s_owner), 32'd0);
    reset = 1'b1; m0_valid = 1'b0;
    tick();
    check("rb_drop", 32'(s_valid), 32'd0);
    check("rb_no_ready", 32'(m0_ready), 32'd0);
    reset = 1'b0;
    slave_mode = 2; ready_at = 1;
    sb.push_back('{1'b1, c_FIXED, 1});
    wait_done(10);
    m1_valid = 1'b0;

    // Fixed priority: M1 never granted while M0 keeps requesting
    n_b = 0;
    b_m0_valid = 1'b1; b_m1_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (b_s_valid) check("prio_owner", 32'(b_s_owner), 32'd0);
      check("prio_m1_ready", 32'(b_m1_ready), 32'd0);
      if (b_m0_ready) n_b++;
    end
    check("prio_m0_grants", 32'(n_b), 32'd20);
    b_m0_valid = 1'b0; b_m1_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
